// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for a downstream 4:1 data mux with bounded bursts.
// Channel k drives sel = 3-k. Handshake: a transfer happens on a rising edge
// where out_valid=1 and out_ready=1. Once out_valid is raised, sel, grant and
// out_valid hold until that transfer, even if the owner drops its request.
module mux_sel_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       out_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // State is kept in a named enum so checkers can bind to it directly.
  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;

  logic [1:0] owner;
  logic [1:0] rel_ptr;
  logic [2:0] idle_pick;
  logic [2:0] rel_pick;
  logic       keep;
  logic       xfer;

  // Search order p, p+1, p+2, p+3 (mod 4); result is {found, index}.
  // Descending loop so the smallest offset is written last and wins.
  function automatic logic [2:0] arb(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      c = p + 2'(i);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  // Owner index and arbitration results for the current cycle.
  always_comb begin
    owner     = ~sel;                 // 3-k == ~k for 2-bit k
    rel_ptr   = owner + 2'd1;
    idle_pick = arb(req, ptr);
    rel_pick  = arb(req, rel_ptr);
    xfer      = out_valid && out_ready;
    keep      = req[owner] && (({1'b0, cnt} + 5'd1) < 5'(MAX_BURST));
  end

  // Single FSM: IDLE/GRANT with registered sel, grant and out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= 4'd0;
      sel       <= 2'b00;
      grant     <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_pick[2]) begin
            state     <= GRANT;
            cnt       <= 4'd0;
            sel       <= ~idle_pick[1:0];
            grant     <= 4'b0001 << idle_pick[1:0];
            out_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (xfer) begin
            if (keep) begin
              cnt <= cnt + 4'd1;
            end else begin
              ptr <= rel_ptr;
              cnt <= 4'd0;
              if (rel_pick[2]) begin
                sel   <= ~rel_pick[1:0];
                grant <= 4'b0001 << rel_pick[1:0];
              end else begin
                // sel keeps its last value while idle.
                state     <= IDLE;
                grant     <= 4'b0000;
                out_valid <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: hand-derived vector table against two instances
// (MAX_BURST=4 and MAX_BURST=1) plus a random run checking hold and
// grant/sel consistency rules.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;

  logic [1:0] sel4, sel1;
  logic [3:0] grant4, grant1;
  logic       valid4, valid1;

  int errors = 0;
  int checks = 0;

  // Expected {out_valid, grant, sel}
  logic [6:0] exp_q[$];

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic       dut;   // 0: MAX_BURST=4 instance, 1: MAX_BURST=1 instance
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  mux_sel_arbiter #(.MAX_BURST(4)) u_mb4 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel4), .grant(grant4), .out_valid(valid4)
  );

  mux_sel_arbiter #(.MAX_BURST(1)) u_mb1 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel1), .grant(grant1), .out_valid(valid1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] q, input logic rdy,
                     input logic d, input logic v, input logic [3:0] g,
                     input logic [1:0] s, input string n);
    vec_t t;
    t.rst_n = r; t.req = q; t.rdy = rdy; t.dut = d;
    t.exp = {v, g, s}; t.name = n;
    vecs.push_back(t);
  endtask

  task automatic check(input string n, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%b g=%b s=%b, expected v=%b g=%b s=%b",
               n, act[6], act[5:2], act[1:0], exp[6], exp[5:2], exp[1:0]);
    end
  endtask

  logic [6:0] exp_v;
  logic [6:0] act_v;
  logic [6:0] prev4;
  logic       prev_rdy;

  initial begin
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;

    // Reset with all requests, then first grant searches from ch0.
    add(0, 4'b1111, 0, 0, 0, 4'b0000, 2'b00, "rst_a");
    add(0, 4'b1111, 0, 0, 0, 4'b0000, 2'b00, "rst_b");
    add(1, 4'b1111, 0, 0, 1, 4'b0001, 2'b11, "rst_first_grant");
    add(1, 4'b1111, 0, 0, 1, 4'b0001, 2'b11, "rst_hold");
    // Burst of 4 on ch2, then re-grant without a bubble.
    add(0, 4'b0100, 1, 0, 0, 4'b0000, 2'b00, "burst_rst");
    add(1, 4'b0100, 1, 0, 1, 4'b0100, 2'b01, "burst_grant");
    add(1, 4'b0100, 1, 0, 1, 4'b0100, 2'b01, "burst_x1");
    add(1, 4'b0100, 1, 0, 1, 4'b0100, 2'b01, "burst_x2");
    add(1, 4'b0100, 1, 0, 1, 4'b0100, 2'b01, "burst_x3");
    add(1, 4'b0100, 1, 0, 1, 4'b0100, 2'b01, "burst_x4_regrant");
    // ch2 releases with ptr=3: ch3 then ch0.
    add(1, 4'b1001, 1, 0, 1, 4'b1000, 2'b00, "wrap_ch3");
    add(1, 4'b0001, 1, 0, 1, 4'b0001, 2'b11, "wrap_ch0");
    add(1, 4'b0000, 1, 0, 0, 4'b0000, 2'b11, "release_idle");
    add(1, 4'b0000, 0, 0, 0, 4'b0000, 2'b11, "idle_sel_hold");
    // Backpressure on ch1 with request dropped and non-owner noise.
    add(1, 4'b0010, 0, 0, 1, 4'b0010, 2'b10, "bp_grant");
    add(1, 4'b1110, 0, 0, 1, 4'b0010, 2'b10, "bp_hold1");
    add(1, 4'b0000, 0, 0, 1, 4'b0010, 2'b10, "bp_hold2");
    add(1, 4'b0000, 0, 0, 1, 4'b0010, 2'b10, "bp_hold3");
    add(1, 4'b0000, 1, 0, 0, 4'b0000, 2'b10, "bp_xfer_idle");
    // Reset mid-burst with out_ready=1.
    add(0, 4'b0100, 0, 0, 0, 4'b0000, 2'b00, "mid_rst_a");
    add(1, 4'b0100, 1, 0, 1, 4'b0100, 2'b01, "mid_grant");
    add(1, 4'b0100, 1, 0, 1, 4'b0100, 2'b01, "mid_x1");
    add(1, 4'b0100, 1, 0, 1, 4'b0100, 2'b01, "mid_x2");
    add(0, 4'b1111, 1, 0, 0, 4'b0000, 2'b00, "mid_rst");
    add(1, 4'b1111, 0, 0, 1, 4'b0001, 2'b11, "mid_after_ch0");
    // MAX_BURST=1 round robin.
    add(0, 4'b1111, 1, 1, 0, 4'b0000, 2'b00, "rr_rst");
    add(1, 4'b1111, 1, 1, 1, 4'b0001, 2'b11, "rr_0");
    add(1, 4'b1111, 1, 1, 1, 4'b0010, 2'b10, "rr_1");
    add(1, 4'b1111, 1, 1, 1, 4'b0100, 2'b01, "rr_2");
    add(1, 4'b1111, 1, 1, 1, 4'b1000, 2'b00, "rr_3");
    add(1, 4'b1111, 1, 1, 1, 4'b0001, 2'b11, "rr_wrap");
    add(1, 4'b1111, 1, 1, 1, 4'b0010, 2'b10, "rr_1b");
    // Sole requester re-granted through the wrap-around search.
    add(1, 4'b0010, 1, 1, 1, 4'b0010, 2'b10, "rr_sole_regrant");

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; req = vecs[i].req; out_ready = vecs[i].rdy;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      act_v = vecs[i].dut ? {valid1, grant1, sel1} : {valid4, grant4, sel4};
      check(vecs[i].name, act_v, exp_v);
    end

    // Random run: hold under backpressure and grant/sel consistency.
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 300; n++) begin
      req       = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) != 0);
      prev4     = {valid4, grant4, sel4};
      prev_rdy  = out_ready;
      @(posedge clk); #1;
      if (prev4[6] && !prev_rdy)
        check("rand_hold", {valid4, grant4, sel4}, prev4);
      if (valid4)
        check("rand_grant_sel", {valid4, grant4, 2'b00},
              {1'b1, 4'b0001 << (~sel4), 2'b00});
      else
        check("rand_idle_grant", {valid4, grant4, 2'b00}, 7'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
